// File: rtl/commit_trace_buffer.sv
// Commit event trace FIFO: buffers retired-instruction records for a trace sink
// and keeps saturating retire/trap/drop counters so lost records are visible.

package cpu_pkg;

    typedef enum logic [3:0] {
        TR_NONE           = 4'd0,
        TR_ILLEGAL_OPCODE = 4'd1,
        TR_MISALIGNED     = 4'd2,
        TR_ECALL          = 4'd3,
        TR_BREAK          = 4'd4
    } trap_code_e;

    // 61-bit commit record, one per retired instruction
    typedef struct packed {
        logic             valid;
        logic [15:0]      pc_before;
        logic [15:0]      pc_after;
        logic             gpr_we;
        logic [2:0]       gpr_addr;
        logic [15:0]      gpr_wdata;
        logic             flags_we;
        logic [1:0]       flags;
        logic             is_trap;
        trap_code_e       trap_code;
    } commit_t;

endpackage

module commit_trace_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  commit_t                    commit_i,
    input  logic                       clear_i,
    output commit_t                    trace_o,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [CNT_W-1:0]           retire_cnt_o,
    output logic [CNT_W-1:0]           trap_cnt_o,
    output logic [CNT_W-1:0]           drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    commit_t          mem [DEPTH];
    commit_t          wr_rec;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, push, pop, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    assign pop   = trace_valid_o && trace_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push  = commit_i.valid && (!full || pop);
    assign drop  = commit_i.valid && full && !pop;

    always_comb begin
        wr_rec       = commit_i;
        wr_rec.valid = 1'b1;
    end

    assign trace_valid_o = !empty;
    assign trace_o       = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign level_o       = wr_ptr_q - rd_ptr_q;
    assign overflow_o    = overflow_q;
    assign retire_cnt_o  = retire_cnt_q;
    assign trap_cnt_o    = trap_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        // Clear beats a same-cycle increment, so that event is not counted
        if (clear_i) begin
            retire_cnt_d = '0;
            trap_cnt_d   = '0;
            drop_cnt_d   = '0;
            overflow_d   = 1'b0;
        end else begin
            retire_cnt_d = sat_inc(retire_cnt_q, commit_i.valid);
            trap_cnt_d   = sat_inc(trap_cnt_q, commit_i.valid && commit_i.is_trap);
            drop_cnt_d   = sat_inc(drop_cnt_q, drop);
            overflow_d   = overflow_q || drop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            retire_cnt_q <= '0;
            trap_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            retire_cnt_q <= retire_cnt_d;
            trap_cnt_q   <= trap_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_rec;
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (DEPTH=8, CNT_W=32).

module tb_commit_trace_buffer;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    commit_t     commit_i;
    logic        clear_i;
    commit_t     trace_o;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [3:0]  level_o;
    logic        overflow_o;
    logic [31:0] retire_cnt_o;
    logic [31:0] trap_cnt_o;
    logic [31:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;
    commit_t idle;
    commit_t exp_q[$];
    commit_t exp_rec;

    commit_trace_buffer #(.DEPTH(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .commit_i(commit_i), .clear_i(clear_i),
        .trace_o(trace_o), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .level_o(level_o), .overflow_o(overflow_o), .retire_cnt_o(retire_cnt_o),
        .trap_cnt_o(trap_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic commit_t mk(input logic [15:0] pc, input logic trap, input trap_code_e code);
        commit_t r;
        r.valid     = 1'b1;
        r.pc_before = pc;
        r.pc_after  = pc + 16'd2;
        r.gpr_we    = pc[0];
        r.gpr_addr  = pc[2:0];
        r.gpr_wdata = pc ^ 16'hA5A5;
        r.flags_we  = 1'b1;
        r.flags     = pc[1:0];
        r.is_trap   = trap;
        r.trap_code = code;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input commit_t c, input logic rdy, input logic clr);
        commit_i      = c;
        trace_ready_i = rdy;
        clear_i       = clr;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " valid"}, 64'(trace_valid_o), 64'd0);
        checkOutput({tag, " trace"}, 64'(trace_o), 64'd0);
        checkOutput({tag, " level"}, 64'(level_o), 64'd0);
        checkOutput({tag, " ovf"}, 64'(overflow_o), 64'd0);
        checkOutput({tag, " retire"}, 64'(retire_cnt_o), 64'd0);
        checkOutput({tag, " trap"}, 64'(trap_cnt_o), 64'd0);
        checkOutput({tag, " drop"}, 64'(drop_cnt_o), 64'd0);
    endtask

    initial begin
        idle          = '0;
        commit_i      = '0;
        clear_i       = 1'b0;
        trace_ready_i = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;

        // Basic flow: each record visible the cycle after its push
        applyStimulus(mk(16'h0000, 1'b0, TR_NONE), 1'b1, 1'b0);
        checkOutput("flow0 head", 64'(trace_o), 64'(mk(16'h0000, 1'b0, TR_NONE)));
        checkOutput("flow0 level", 64'(level_o), 64'd1);
        applyStimulus(mk(16'h0001, 1'b0, TR_NONE), 1'b1, 1'b0);
        checkOutput("flow1 head", 64'(trace_o), 64'(mk(16'h0001, 1'b0, TR_NONE)));
        applyStimulus(mk(16'h0002, 1'b0, TR_NONE), 1'b1, 1'b0);
        checkOutput("flow2 head", 64'(trace_o), 64'(mk(16'h0002, 1'b0, TR_NONE)));
        applyStimulus(idle, 1'b1, 1'b0);
        checkOutput("flow empty valid", 64'(trace_valid_o), 64'd0);
        checkOutput("flow empty trace", 64'(trace_o), 64'd0);
        checkOutput("flow level", 64'(level_o), 64'd0);
        checkOutput("flow retire", 64'(retire_cnt_o), 64'd3);

        // Fill and overflow with 10 commits into 8 entries
        applyStimulus(idle, 1'b0, 1'b1);
        checkOutput("clear retire", 64'(retire_cnt_o), 64'd0);
        for (int i = 0; i < 10; i++)
            applyStimulus(mk(16'h0010 + 16'(i), 1'b0, TR_NONE), 1'b0, 1'b0);
        checkOutput("fill level", 64'(level_o), 64'd8);
        checkOutput("fill drop", 64'(drop_cnt_o), 64'd2);
        checkOutput("fill ovf", 64'(overflow_o), 64'd1);
        checkOutput("fill retire", 64'(retire_cnt_o), 64'd10);
        checkOutput("fill head", 64'(trace_o), 64'(mk(16'h0010, 1'b0, TR_NONE)));

        // Full with simultaneous push and pop
        applyStimulus(mk(16'h0020, 1'b0, TR_NONE), 1'b1, 1'b0);
        checkOutput("fullpp level", 64'(level_o), 64'd8);
        checkOutput("fullpp drop", 64'(drop_cnt_o), 64'd2);
        checkOutput("fullpp retire", 64'(retire_cnt_o), 64'd11);
        exp_q = {};
        for (int i = 1; i < 8; i++) exp_q.push_back(mk(16'h0010 + 16'(i), 1'b0, TR_NONE));
        exp_q.push_back(mk(16'h0020, 1'b0, TR_NONE));
        for (int i = 0; i < 8; i++) begin
            exp_rec = exp_q.pop_front();
            checkOutput($sformatf("drain%0d", i), 64'(trace_o), 64'(exp_rec));
            applyStimulus(idle, 1'b1, 1'b0);
        end
        checkOutput("drain valid", 64'(trace_valid_o), 64'd0);
        checkOutput("drain level", 64'(level_o), 64'd0);

        // Backpressure: trap record held stable for 5 cycles
        applyStimulus(idle, 1'b0, 1'b1);
        exp_rec = mk(16'h0030, 1'b1, TR_ILLEGAL_OPCODE);
        applyStimulus(exp_rec, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("hold%0d trace", k), 64'(trace_o), 64'(exp_rec));
            checkOutput($sformatf("hold%0d trap", k), 64'(trap_cnt_o), 64'd1);
            applyStimulus(idle, 1'b0, 1'b0);
        end
        applyStimulus(idle, 1'b1, 1'b0);
        checkOutput("hold release", 64'(trace_valid_o), 64'd0);

        // Clear versus a same-cycle trap commit, after an overflow
        for (int i = 0; i < 9; i++)
            applyStimulus(mk(16'h0050 + 16'(i), 1'b0, TR_NONE), 1'b0, 1'b0);
        checkOutput("pre-clear ovf", 64'(overflow_o), 64'd1);
        for (int i = 0; i < 8; i++) applyStimulus(idle, 1'b1, 1'b0);
        exp_rec = mk(16'h0040, 1'b1, TR_ECALL);
        applyStimulus(exp_rec, 1'b0, 1'b1);
        checkOutput("clr retire", 64'(retire_cnt_o), 64'd0);
        checkOutput("clr trap", 64'(trap_cnt_o), 64'd0);
        checkOutput("clr drop", 64'(drop_cnt_o), 64'd0);
        checkOutput("clr ovf", 64'(overflow_o), 64'd0);
        checkOutput("clr level", 64'(level_o), 64'd1);
        checkOutput("clr head", 64'(trace_o), 64'(exp_rec));

        // Reset mid-operation with level 5 and overflow set
        for (int i = 0; i < 8; i++)
            applyStimulus(mk(16'h0080 + 16'(i), 1'b0, TR_NONE), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(idle, 1'b1, 1'b0);
        checkOutput("pre-rst level", 64'(level_o), 64'd5);
        checkOutput("pre-rst ovf", 64'(overflow_o), 64'd1);
        rst = 1'b1;
        applyStimulus(mk(16'h0070, 1'b1, TR_BREAK), 1'b1, 1'b0);
        checkAllZero("midrst");
        rst = 1'b0;
        exp_rec = mk(16'h0060, 1'b0, TR_NONE);
        applyStimulus(exp_rec, 1'b0, 1'b0);
        checkOutput("post-rst head", 64'(trace_o), 64'(exp_rec));
        checkOutput("post-rst level", 64'(level_o), 64'd1);
        checkOutput("post-rst retire", 64'(retire_cnt_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the core's commit interface. Consumes the once-per-instruction commit_t event stream from cpu_pkg.
- Buffers events in a FIFO and drains them over a valid/ready port to a trace sink (sim logger, debug UART bridge or checker).
- Keeps retire, trap and drop counters, so lost trace records are always detectable.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 32, width of the retire, trap and drop counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- commit_i  in  $bits(cpu_pkg::commit_t) (61)  commit event; sampled only when commit_i.valid=1.
- clear_i  in  1  synchronous clear of the counters and the overflow flag; FIFO contents are kept.
- trace_o  out  61  head record, commit_t layout; trace_o.valid mirrors trace_valid_o.
- trace_valid_o  out  1  head record available.
- trace_ready_i  in  1  sink accepts the head record.
- level_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: at least one event dropped since reset or clear.
- retire_cnt_o  out  CNT_W  count of commit_i.valid events.
- trap_cnt_o  out  CNT_W  count of commit_i.valid events with is_trap=1.
- drop_cnt_o  out  CNT_W  count of events dropped because the FIFO was full.

Behaviour:
- Storage: circular buffer of DEPTH commit_t records.
  - rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Push: push = commit_i.valid && (!full || pop). The record is stored with its valid bit forced to 1.
- Pop: pop = trace_valid_o && trace_ready_i. rd_ptr advances on pop.
- Latency: a record pushed in cycle N appears at trace_o in cycle N+1 at the earliest. There is no combinational bypass from commit_i to trace_o.
- Output timing: trace_valid_o = !empty, with no dependence on trace_ready_i. trace_o is a registered read or a mux on rd_ptr.
- Hold: while trace_valid_o=1 && trace_ready_i=0, trace_o must stay bit-stable.
- Output when empty: trace_valid_o=0 and trace_o is all zeros.
- Full with a simultaneous pop: the push is accepted. level_o is unchanged and nothing is dropped.
- Full without a pop: the event is discarded and the FIFO contents are unchanged. drop_cnt_o increments and overflow_o sets.
- Counters:
  - retire_cnt_o increments on every commit_i.valid, whether pushed or dropped.
  - trap_cnt_o increments when commit_i.valid && commit_i.is_trap.
  - All counters saturate at all-ones and never wrap.
- Level: level_o = wr_ptr - rd_ptr in pointer width. It is +1 on push only, -1 on pop only, and unchanged on both or neither.
- clear_i: in that cycle the three counters go to 0 and overflow_o goes to 0. Clear takes priority over a same-cycle increment; that event is not counted. FIFO push and pop proceed normally.
- Reset (rst=1, any cycle including mid-drain):
  - Pointers, counters and overflow_o are set to 0.
  - Outputs are 0: trace_valid_o=0, trace_o=0, level_o=0, overflow_o=0, all counters 0.
  - Events presented during reset are neither stored nor counted.
  - Storage array contents need no reset.
- Fields pass through bit-exact (pc_before, pc_after, gpr_*, flags_*, trap_code). The block never interprets them except is_trap.

Test Plan:
- Basic flow: push 3 commits with pc_before=0x0000, 0x0001, 0x0002 and trace_ready_i=1 -> records emerge in order, one cycle after each push. retire_cnt_o=3, level_o returns to 0.
- Fill and overflow: DEPTH=8, trace_ready_i=0, 10 consecutive valid commits -> level_o=8, drop_cnt_o=2, overflow_o=1, retire_cnt_o=10. The draining stream then holds exactly the first 8 records.
- Full with push and pop in the same cycle: FIFO full, then one cycle with commit_i.valid=1 and trace_ready_i=1 -> level_o stays 8, drop_cnt_o unchanged. The new record exits 8 pops later.
- Backpressure stability: head record with is_trap=1, trap_code=TR_ILLEGAL_OPCODE, trace_ready_i=0 for 5 cycles -> trace_o stays constant throughout and trap_cnt_o=1.
- Clear versus increment: clear_i=1 in the same cycle as a valid trap commit -> all counters 0 and overflow_o=0 next cycle. The record is still enqueued and level_o increments.
- Reset mid-operation: rst=1 with level_o=5 and overflow_o=1 -> next cycle every output is 0. The first post-reset push appears intact after one cycle.
